// File: rtl/zb_pkg.sv
// zb_pkg: shared types and constants for the O-QPSK chip spreader.
// Optional feature macro: ZB_PREAMBLE_EN adds the PREAMBLE and SFD states.
package zb_pkg;

   // One 4-bit data symbol as written by the CPU
   typedef logic [3:0] sym_t;

   // Spreader states; the header states exist only when the preamble is built in
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1
`ifdef ZB_PREAMBLE_EN
      ,
      ST_PREAMBLE = 2'd2,
      ST_SFD      = 2'd3
`endif
   } state_t;

   // Start-of-frame delimiter, sent low symbol first
   localparam sym_t SFD_SYM0 = 4'h7;
   localparam sym_t SFD_SYM1 = 4'hA;

   // 802.15.4 2.4 GHz symbol-to-chip table, chip c0 is bit 31 of each word
   localparam logic [15:0][31:0] CHIP_TABLE = {
      32'hC96077B8, 32'h96077B8C, 32'h6077B8C9, 32'h077B8C96,
      32'h77B8C960, 32'h7B8C9607, 32'hB8C96077, 32'h8C96077B,
      32'h9C3522ED, 32'hC3522ED9, 32'h3522ED9C, 32'h522ED9C3,
      32'h22ED9C35, 32'h2ED9C352, 32'hED9C3522, 32'hD9C3522E
   };

   // Chip number idx (0 = first transmitted) of symbol s
   function automatic logic chip_of(input sym_t s, input logic [4:0] idx);
      logic [31:0] word;
      word = CHIP_TABLE[s];
      return word[5'd31 - idx];
   endfunction

endpackage

// File: rtl/zb_sym_fifo.sv
// zb_sym_fifo: symbol FIFO with registered read port and full/empty flags.
// A push while full is accepted only if a pop happens in the same cycle.
module zb_sym_fifo
   import zb_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  sym_t push_data,
   input  logic pop,
   output sym_t pop_data,
   output logic full,
   output logic empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   sym_t             mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   sym_t             pop_data_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_reg == CNT_W'(DEPTH));
   assign empty    = (count_reg == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = pop_data_reg;

   // Storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers, occupancy and registered read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         pop_data_reg <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            pop_data_reg <= mem[rd_ptr_reg];
         end
         if (push_ok && !pop_ok) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/zb_spread_tx.sv
// zb_spread_tx: CPU symbol FIFO feeding an 802.15.4 DSSS chip spreader with
// O-QPSK I/Q split. Optional macro ZB_PREAMBLE_EN prepends a preamble of
// PREAMBLE_SYMS zero symbols and the two SFD symbols to every frame.
// Outputs are registered one cycle behind the chip counters.
module zb_spread_tx
   import zb_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int CHIP_DIV      = 2,
   parameter int PREAMBLE_SYMS = 8
)(
   input  logic       inClock,
   input  logic       inReset,
   input  logic       inWriteEnable,
   input  logic [3:0] inCPUdata,
   input  logic       inErrClear,
   output logic       outFull,
   output logic       outEmpty,
   output logic       outError,
   output logic       o_busy,
   output logic       o_chipValid,
   output logic       o_chip,
   output logic       o_sinI,
   output logic       o_sinQ
);

   localparam int               DIV_W    = $clog2(CHIP_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [4:0]       chip_idx_reg, chip_idx_next;
   logic             chip_reg, valid_reg, sin_i_reg, sin_q_reg, error_reg;
   logic             pop;
   sym_t             fifo_data;
   logic             fifo_full, fifo_empty;
   logic             chip_last, sym_end, overflow;
   sym_t             cur_sym;
   logic             cur_chip;

   zb_sym_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (inClock),
      .rst       (inReset),
      .push      (inWriteEnable),
      .push_data (inCPUdata),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign chip_last = (div_reg == DIV_LAST);
   assign sym_end   = chip_last && (chip_idx_reg == 5'd31);
   assign overflow  = inWriteEnable && fifo_full && !pop;

`ifdef ZB_PREAMBLE_EN
   localparam int PRE_W = $clog2(PREAMBLE_SYMS + 1);

   sym_t             hdr_sym_reg, hdr_sym_next;
   logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;

   assign cur_sym = (state_reg == ST_DATA) ? fifo_data : hdr_sym_reg;

   // Header symbol and preamble repeat count
   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         hdr_sym_reg <= '0;
         pre_cnt_reg <= '0;
      end else begin
         hdr_sym_reg <= hdr_sym_next;
         pre_cnt_reg <= pre_cnt_next;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (PREAMBLE_SYMS != 0);
   assign cur_sym    = fifo_data;
`endif

   assign cur_chip = chip_of(cur_sym, chip_idx_reg);

   // State, chip divider and chip index registers
   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         state_reg    <= ST_IDLE;
         div_reg      <= '0;
         chip_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         div_reg      <= div_next;
         chip_idx_reg <= chip_idx_next;
      end
   end

   // Next state, counter advance and FIFO pop at symbol boundaries
   always_comb begin
      state_next    = state_reg;
      div_next      = div_reg;
      chip_idx_next = chip_idx_reg;
      pop           = 1'b0;
`ifdef ZB_PREAMBLE_EN
      hdr_sym_next  = hdr_sym_reg;
      pre_cnt_next  = pre_cnt_reg;
`endif
      if (state_reg != ST_IDLE) begin
         if (chip_last) begin
            div_next      = '0;
            chip_idx_next = chip_idx_reg + 5'd1;
         end else begin
            div_next = div_reg + 1'b1;
         end
      end
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               div_next      = '0;
               chip_idx_next = '0;
`ifdef ZB_PREAMBLE_EN
               state_next    = ST_PREAMBLE;
               hdr_sym_next  = '0;
               pre_cnt_next  = '0;
`else
               pop           = 1'b1;
               state_next    = ST_DATA;
`endif
            end
         end
         ST_DATA: begin
            if (sym_end) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
`ifdef ZB_PREAMBLE_EN
         ST_PREAMBLE: begin
            if (sym_end) begin
               if (pre_cnt_reg == PRE_W'(PREAMBLE_SYMS - 1)) begin
                  state_next   = ST_SFD;
                  hdr_sym_next = SFD_SYM0;
               end else begin
                  pre_cnt_next = pre_cnt_reg + 1'b1;
               end
            end
         end
         ST_SFD: begin
            if (sym_end) begin
               if (hdr_sym_reg == SFD_SYM0) begin
                  hdr_sym_next = SFD_SYM1;
               end else if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = ST_DATA;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Chip outputs: load a new chip on the first divider cycle, even chips to I, odd to Q
   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         chip_reg  <= 1'b0;
         valid_reg <= 1'b0;
         sin_i_reg <= 1'b0;
         sin_q_reg <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
         chip_reg  <= 1'b0;
         valid_reg <= 1'b0;
         sin_i_reg <= 1'b0;
         sin_q_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b1;
         if (div_reg == '0) begin
            chip_reg <= cur_chip;
            if (chip_idx_reg[0]) begin
               sin_q_reg <= cur_chip;
            end else begin
               sin_i_reg <= cur_chip;
            end
         end
      end
   end

   // Sticky overflow flag; clear wins over a same-cycle overflow
   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         error_reg <= 1'b0;
      end else if (inErrClear) begin
         error_reg <= 1'b0;
      end else if (overflow) begin
         error_reg <= 1'b1;
      end
   end

   assign outFull     = fifo_full;
   assign outEmpty    = fifo_empty;
   assign outError    = error_reg;
   assign o_busy      = (state_reg != ST_IDLE);
   assign o_chipValid = valid_reg;
   assign o_chip      = chip_reg;
   assign o_sinI      = sin_i_reg;
   assign o_sinQ      = sin_q_reg;

endmodule

// File: tb/tb_zb_spread_tx.sv
// tb_zb_spread_tx: scenario tasks with randomized symbols, checked against a
// chip-stream model built from the base 802.15.4 sequence by rotation/inversion.
// Honours ZB_PREAMBLE_EN by prepending the frame header to the model stream.
module tb_zb_spread_tx;

   localparam int FIFO_DEPTH    = 8;
   localparam int CHIP_DIV      = 2;
   localparam int PREAMBLE_SYMS = 8;
`ifdef ZB_PREAMBLE_EN
   localparam int PRE_OCC = 1;
`else
   localparam int PRE_OCC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inWriteEnable = 1'b0;
   logic [3:0] inCPUdata = 4'h0;
   logic       inErrClear = 1'b0;
   logic       outFull, outEmpty, outError, o_busy, o_chipValid, o_chip, o_sinI, o_sinQ;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   zb_spread_tx #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .CHIP_DIV      (CHIP_DIV),
      .PREAMBLE_SYMS (PREAMBLE_SYMS)
   ) dut (
      .inClock       (clk),
      .inReset       (rst),
      .inWriteEnable (inWriteEnable),
      .inCPUdata     (inCPUdata),
      .inErrClear    (inErrClear),
      .outFull       (outFull),
      .outEmpty      (outEmpty),
      .outError      (outError),
      .o_busy        (o_busy),
      .o_chipValid   (o_chipValid),
      .o_chip        (o_chip),
      .o_sinI        (o_sinI),
      .o_sinQ        (o_sinQ)
   );

   // Chip word from the rule: symbol 0 rotated right 4n chips, odd chips inverted for n>=8
   function automatic logic [31:0] model_word(input int s);
      logic [31:0] base, w;
      int r;
      base = 32'hD9C3522E;
      r = (s % 8) * 4;
      w = (r == 0) ? base : ((base >> r) | (base << (32 - r)));
      if (s >= 8) w = w ^ 32'h55555555;
      return w;
   endfunction

   function automatic void append_symbol(input int s);
      logic [31:0] w;
      w = model_word(s);
      for (int j = 31; j >= 0; j--) exp_q.push_back(w[j]);
   endfunction

   function automatic void start_frame();
      exp_q.delete();
`ifdef ZB_PREAMBLE_EN
      for (int h = 0; h < PREAMBLE_SYMS; h++) append_symbol(0);
      append_symbol(7);
      append_symbol(10);
`endif
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({outEmpty, outFull, outError, o_busy, o_chipValid, o_chip, o_sinI, o_sinQ} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_hold got e/f/err/busy/v/c/i/q=%b%b%b%b%b%b%b%b want 10000000",
                  outEmpty, outFull, outError, o_busy, o_chipValid, o_chip, o_sinI, o_sinQ);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({outEmpty, o_busy, o_chipValid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release got e/busy/v=%b%b%b want 100", outEmpty, o_busy, o_chipValid);
      end
      $display("reset: done");
   endtask

   task automatic test_single();
      int syms[$];
      int len, g;
      bit ev, ec, ei, eq;
      syms = '{11, 3, int'($urandom_range(0, 15))};
      foreach (syms[si]) begin
         start_frame();
         append_symbol(syms[si]);
         len = exp_q.size() * CHIP_DIV;
         for (int k = 0; k < len + 6; k++) begin
            inWriteEnable = (k == 0);
            inCPUdata = 4'(syms[si]);
            @(posedge clk);
            @(negedge clk);
            inWriteEnable = 1'b0;
            {ev, ec, ei, eq} = 4'b0000;
            if (k >= 2 && k - 2 < len) begin
               g  = (k - 2) / CHIP_DIV;
               ev = 1'b1;
               ec = exp_q[g];
               ei = exp_q[g - (g % 2)];
               eq = (g == 0) ? 1'b0 : exp_q[(g % 2 == 1) ? g : g - 1];
            end
            checks++;
            if ({o_chipValid, o_chip, o_sinI, o_sinQ} !== {ev, ec, ei, eq}) begin
               errors++;
               $display("FAIL single sym=%0d k=%0d got v/c/i/q=%b%b%b%b want %b%b%b%b",
                        syms[si], k, o_chipValid, o_chip, o_sinI, o_sinQ, ev, ec, ei, eq);
            end
         end
         checks++;
         if (o_busy !== 1'b0 || outEmpty !== 1'b1) begin
            errors++;
            $display("FAIL single_idle sym=%0d got busy/empty=%b%b want 01", syms[si], o_busy, outEmpty);
         end
         $display("single: symbol %0d streamed %0d chips", syms[si], exp_q.size());
      end
   endtask

   task automatic test_sin_iq();
      int len, g, ph;
      bit ei, eq;
      logic prev_i, prev_q;
      start_frame();
      append_symbol(0);
      len = exp_q.size() * CHIP_DIV;
      prev_i = 1'b0;
      prev_q = 1'b0;
      for (int k = 0; k < len + 4; k++) begin
         inWriteEnable = (k == 0);
         inCPUdata = 4'h0;
         @(posedge clk);
         @(negedge clk);
         inWriteEnable = 1'b0;
         if (k >= 2 && k - 2 < len) begin
            g  = (k - 2) / CHIP_DIV;
            ph = (k - 2) % (2 * CHIP_DIV);
            ei = exp_q[g - (g % 2)];
            eq = (g == 0) ? 1'b0 : exp_q[(g % 2 == 1) ? g : g - 1];
            checks++;
            if ({o_sinI, o_sinQ} !== {ei, eq}) begin
               errors++;
               $display("FAIL iq_value k=%0d got i/q=%b%b want %b%b", k, o_sinI, o_sinQ, ei, eq);
            end
            if (o_sinI !== prev_i) begin
               checks++;
               if (ph != 0) begin
                  errors++;
                  $display("FAIL i_edge k=%0d got phase %0d want 0", k, ph);
               end
            end
            if (o_sinQ !== prev_q) begin
               checks++;
               if (ph != CHIP_DIV) begin
                  errors++;
                  $display("FAIL q_edge k=%0d got phase %0d want %0d", k, ph, CHIP_DIV);
               end
            end
         end
         prev_i = o_sinI;
         prev_q = o_sinQ;
      end
      $display("sin_iq: symbol 0 I/Q checked over %0d cycles", len);
   endtask

   task automatic test_back_to_back();
      int wr_at[$], wr_sym[$];
      int len, g, idx, n, off;
      bit ev, ec, ei, eq;
      for (int r = 0; r < 4; r++) begin
         wr_at.delete();
         wr_sym.delete();
         if (r == 0) begin
            wr_sym = '{15, 14, 5, 10};
            wr_at  = '{0, 6, 12, 18};
         end else begin
            n = $urandom_range(2, 6);
            off = 0;
            for (int i = 0; i < n; i++) begin
               wr_at.push_back(off);
               wr_sym.push_back($urandom_range(0, 15));
               off += $urandom_range(1, 40);
            end
         end
         start_frame();
         foreach (wr_sym[i]) append_symbol(wr_sym[i]);
         len = exp_q.size() * CHIP_DIV;
         idx = 0;
         for (int k = 0; k < len + 6; k++) begin
            inWriteEnable = 1'b0;
            if (idx < wr_at.size() && wr_at[idx] == k) begin
               inWriteEnable = 1'b1;
               inCPUdata = 4'(wr_sym[idx]);
               idx++;
            end
            @(posedge clk);
            @(negedge clk);
            inWriteEnable = 1'b0;
            {ev, ec, ei, eq} = 4'b0000;
            if (k >= 2 && k - 2 < len) begin
               g  = (k - 2) / CHIP_DIV;
               ev = 1'b1;
               ec = exp_q[g];
               ei = exp_q[g - (g % 2)];
               eq = (g == 0) ? 1'b0 : exp_q[(g % 2 == 1) ? g : g - 1];
            end
            checks++;
            if ({o_chipValid, o_chip, o_sinI, o_sinQ} !== {ev, ec, ei, eq}) begin
               errors++;
               $display("FAIL b2b round=%0d k=%0d got v/c/i/q=%b%b%b%b want %b%b%b%b",
                        r, k, o_chipValid, o_chip, o_sinI, o_sinQ, ev, ec, ei, eq);
            end
         end
         $display("back_to_back: round %0d, %0d symbols, %0d chips", r, wr_sym.size(), exp_q.size());
      end
   endtask

   task automatic test_overflow();
      int wsym[9];
      int s0, occ, len, g;
      bit err, we, clr, ev, ec;
      s0 = $urandom_range(0, 15);
      foreach (wsym[i]) wsym[i] = $urandom_range(0, 15);
      start_frame();
      append_symbol(s0);
      occ = PRE_OCC;
      foreach (wsym[i]) begin
         if (occ < FIFO_DEPTH) begin
            append_symbol(wsym[i]);
            occ++;
         end
      end
      len = exp_q.size() * CHIP_DIV;
      occ = PRE_OCC;
      err = 1'b0;
      for (int k = 0; k < len + 6; k++) begin
         we  = (k == 0) || (k >= 4 && k <= 12) || (k == 31) || (k == 33);
         clr = (k == 30) || (k == 31) || (k == 34);
         inWriteEnable = we;
         inErrClear = clr;
         inCPUdata = (k == 0) ? 4'(s0) : (k >= 4 && k <= 12) ? 4'(wsym[k - 4]) : 4'($urandom_range(0, 15));
         if (k >= 4 && k <= 40) begin
            if (we) begin
               if (occ < FIFO_DEPTH) occ++;
               else if (!clr) err = 1'b1;
            end
            if (clr) err = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         inWriteEnable = 1'b0;
         inErrClear = 1'b0;
         if (k >= 4 && k <= 40) begin
            checks++;
            if (outFull !== (occ == FIFO_DEPTH) || outError !== err) begin
               errors++;
               $display("FAIL overflow_flags k=%0d got full/err=%b%b want %b%b",
                        k, outFull, outError, (occ == FIFO_DEPTH), err);
            end
         end
         ev = 1'b0;
         ec = 1'b0;
         if (k >= 2 && k - 2 < len) begin
            g  = (k - 2) / CHIP_DIV;
            ev = 1'b1;
            ec = exp_q[g];
         end
         checks++;
         if ({o_chipValid, o_chip} !== {ev, ec}) begin
            errors++;
            $display("FAIL overflow_stream k=%0d got v/c=%b%b want %b%b", k, o_chipValid, o_chip, ev, ec);
         end
      end
      $display("overflow: 9 writes with FIFO_DEPTH=%0d, stream of %0d chips", FIFO_DEPTH, exp_q.size());
   endtask

   task automatic test_reset_mid();
      int s0, k;
      bit ec;
      s0 = $urandom_range(0, 15);
      start_frame();
      append_symbol(s0);
      k = 0;
      while (k - 2 < 17 * CHIP_DIV + 32 * CHIP_DIV * PRE_OCC * (PREAMBLE_SYMS + 2)) begin
         inWriteEnable = (k == 0) || (k == 3) || (k == 5);
         inCPUdata = (k == 0) ? 4'(s0) : 4'($urandom_range(0, 15));
         @(posedge clk);
         @(negedge clk);
         inWriteEnable = 1'b0;
         k++;
      end
      ec = exp_q[(k - 3) / CHIP_DIV];
      checks++;
      if ({o_chipValid, o_chip} !== {1'b1, ec}) begin
         errors++;
         $display("FAIL reset_mid_pre got v/c=%b%b want 1%b", o_chipValid, o_chip, ec);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({outEmpty, outFull, outError, o_busy, o_chipValid, o_chip, o_sinI, o_sinQ} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_mid got e/f/err/busy/v/c/i/q=%b%b%b%b%b%b%b%b want 10000000",
                  outEmpty, outFull, outError, o_busy, o_chipValid, o_chip, o_sinI, o_sinQ);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 150; j++) begin
         @(negedge clk);
         checks++;
         if ({o_chipValid, o_chip, o_busy, outEmpty} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_after j=%0d got v/c/busy/empty=%b%b%b%b want 0001",
                     j, o_chipValid, o_chip, o_busy, outEmpty);
         end
      end
      $display("reset_mid: symbol %0d aborted at chip 17", s0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_sin_iq();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL watchdog got timeout want completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
